// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_W = 32;

  localparam logic [FETCH_W-1:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam logic [FETCH_W-1:0] FETCH_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } fetch_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [FETCH_W-1:0] sat_inc(input logic [FETCH_W-1:0] v);
    return (v == {FETCH_W{1'b1}}) ? v : v + FETCH_W'(1);
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch / flush event counters for the fetch stage (FETCH_PERF_EN builds).
module fetch_perf_counters
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_fetch_inc,
  input  logic               i_flush_inc,
  output logic [FETCH_W-1:0] o_perf_fetched,
  output logic [FETCH_W-1:0] o_perf_flushed
);

  logic [FETCH_W-1:0] r_fetched;
  logic [FETCH_W-1:0] r_flushed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetched <= '0;
      r_flushed <= '0;
    end else begin
      if (i_fetch_inc) r_fetched <= sat_inc(r_fetched);
      if (i_flush_inc) r_flushed <= sat_inc(r_flushed);
    end
  end

  assign o_perf_fetched = r_fetched;
  assign o_perf_flushed = r_flushed;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and redirect handling.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [FETCH_W-1:0] RESET_PC = FETCH_RESET_PC,
  parameter logic [FETCH_W-1:0] NOP_WORD = FETCH_NOP_WORD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [FETCH_W-1:0] i_redirect_target,
  input  logic               i_flush,
  output logic [FETCH_W-1:0] o_imem_addr,
  input  logic [FETCH_W-1:0] i_imem_instr,
  output logic [FETCH_W-1:0] o_ifid_instr,
  output logic [FETCH_W-1:0] o_ifid_pc,
  output logic [FETCH_W-1:0] o_ifid_pc_plus1,
`ifdef FETCH_PERF_EN
  output logic               o_ifid_valid,
  output logic [FETCH_W-1:0] o_perf_fetched,
  output logic [FETCH_W-1:0] o_perf_flushed
`else
  output logic               o_ifid_valid
`endif
);

  fetch_state_e       r_state;
  logic [FETCH_W-1:0] r_pc;
  logic [FETCH_W-1:0] r_ifid_instr;
  logic [FETCH_W-1:0] r_ifid_pc;
  logic [FETCH_W-1:0] r_ifid_pc_plus1;
  logic               r_ifid_valid;

  // Redirect beats stall and flush; flush bubbles IF/ID but still lets the PC advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_BOOT;
      r_pc            <= RESET_PC;
      r_ifid_instr    <= NOP_WORD;
      r_ifid_pc       <= '0;
      r_ifid_pc_plus1 <= '0;
      r_ifid_valid    <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        default: begin
          if (i_redirect) begin
            r_pc         <= i_redirect_target;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_WORD;
            r_state      <= ST_REDIR;
          end else begin
            r_state <= ST_RUN;
            if (i_flush) begin
              r_ifid_valid <= 1'b0;
              r_ifid_instr <= NOP_WORD;
            end else if (!i_stall) begin
              r_ifid_valid    <= 1'b1;
              r_ifid_instr    <= i_imem_instr;
              r_ifid_pc       <= r_pc;
              r_ifid_pc_plus1 <= r_pc + FETCH_W'(1);
            end
            if (!i_stall) r_pc <= r_pc + FETCH_W'(1);
          end
        end
      endcase
    end
  end

  assign o_imem_addr     = r_pc;
  assign o_ifid_instr    = r_ifid_instr;
  assign o_ifid_pc       = r_ifid_pc;
  assign o_ifid_pc_plus1 = r_ifid_pc_plus1;
  assign o_ifid_valid    = r_ifid_valid;

`ifdef FETCH_PERF_EN
  logic w_active;
  logic w_fetch_inc;
  logic w_flush_inc;

  // Count fresh captures, and bubbles that actually kill a valid entry.
  assign w_active    = (r_state != ST_BOOT);
  assign w_fetch_inc = w_active & ~i_redirect & ~i_flush & ~i_stall;
  assign w_flush_inc = w_active & (i_redirect | i_flush) & r_ifid_valid;

  fetch_perf_counters u_perf (
    .clk            (clk),
    .rst            (rst),
    .i_fetch_inc    (w_fetch_inc),
    .i_flush_inc    (w_flush_inc),
    .o_perf_fetched (o_perf_fetched),
    .o_perf_flushed (o_perf_flushed)
  );
`endif

endmodule
